// File: rtl/alu_op_seq.sv
// ---------------------------------------------------------------------------
// alu_op_seq
//
// Sequential ALU execution stage. Sits directly after the A/B operand-select
// muxes and takes one operation at a time through a valid/ready handshake.
// Single-cycle operations register their result on the accept edge; multiply
// is an unsigned WIDTH-cycle shift-add. The result and its carry/zero flags
// are held until the downstream consumer takes them.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operands/opcode valid
//   in_ready   stage can accept a new operation (high only in IDLE)
//   op         opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//              101 PASS_B, 110 MUL, 111 PASS_A
//   a, b       WIDTH-bit operands
//   out_valid  result/flags valid (high only in DONE)
//   out_ready  downstream accepts the result
//   result     WIDTH-bit result
//   carry      carry (ADD), borrow (SUB), high-half-nonzero (MUL), else 0
//   zero       result == 0
// ---------------------------------------------------------------------------
module alu_op_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    // Step counter must hold 0..WIDTH-1.
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_PASSB = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;
    localparam logic [2:0] OP_PASSA = 3'b111;

    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      step_q, step_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;

    logic               accept;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     diff_ext;
    logic [WIDTH-1:0]   alu_result;
    logic               alu_carry;
    logic [2*WIDTH-1:0] acc_step;
    logic               last_step;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;

    assign accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    // One extra bit on each side exposes carry-out / borrow directly.
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        case (op)
            OP_ADD: begin
                alu_result = sum_ext[WIDTH-1:0];
                alu_carry  = sum_ext[WIDTH];
            end
            OP_SUB: begin
                alu_result = diff_ext[WIDTH-1:0];
                alu_carry  = diff_ext[WIDTH];
            end
            OP_AND:   alu_result = a & b;
            OP_OR:    alu_result = a | b;
            OP_XOR:   alu_result = a ^ b;
            OP_PASSB: alu_result = b;
            OP_PASSA: alu_result = a;
            // MUL never takes this path; it goes through the shift-add engine.
            default: begin
                alu_result = '0;
                alu_carry  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shift-add multiplier step
    // ------------------------------------------------------------------
    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_step = (step_q == LAST_STEP);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        step_d   = step_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        state_d  = ST_BUSY;
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        acc_d    = '0;
                        step_d   = '0;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = alu_result;
                        carry_d  = alu_carry;
                        zero_d   = (alu_result == '0);
                    end
                end
            end

            ST_BUSY: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                step_d   = step_q + CW'(1);
                // Always WIDTH steps, even when the multiplier runs out early.
                if (last_step) begin
                    state_d  = ST_DONE;
                    result_d = acc_step[WIDTH-1:0];
                    carry_d  = |acc_step[2*WIDTH-1:WIDTH];
                    zero_d   = (acc_step[WIDTH-1:0] == '0);
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            // Unused encoding: recover to a safe idle.
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            step_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            step_q   <= step_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu_op_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_op_seq
//
// Self-checking bench for alu_op_seq (WIDTH = 8). Directed cases cover reset,
// carry/borrow/zero boundaries, multiply latency, backpressure and abort;
// randomized operations are then compared against an arithmetic reference.
// ---------------------------------------------------------------------------
module tb_alu_op_seq;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;

    int n_checks = 0;
    int n_pass   = 0;

    alu_op_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Reference: plain integer arithmetic on the opcode rules.
    // Returns {carry, result}.
    function automatic int ref_op(input int o, input int x, input int y);
        int m;
        int r;
        int c;
        m = 1 << W;
        c = 0;
        case (o)
            0: begin r = (x + y) % m;     c = ((x + y) >= m) ? 1 : 0; end
            1: begin r = (x - y + m) % m; c = (x < y) ? 1 : 0;        end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: r = y;
            6: begin r = (x * y) % m;     c = ((x * y) >= m) ? 1 : 0; end
            default: r = x;
        endcase
        return (c << W) | r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, measure latency, check flags, optionally apply
    // backpressure for 'hold' cycles, then complete the output handshake.
    task automatic run_op(input int o, input int x, input int y, input int hold,
                          input string tag);
        int exp;
        int exp_res;
        int exp_c;
        int edges;
        int lat_exp;
        exp     = ref_op(o, x, y);
        exp_res = exp & ((1 << W) - 1);
        exp_c   = (exp >> W) & 1;
        lat_exp = (o == 6) ? W + 1 : 1;

        check({tag, ".in_ready_pre"}, int'(in_ready), 1);
        in_valid = 1'b1;
        op       = 3'(o);
        a        = W'(x);
        b        = W'(y);
        tick();
        in_valid = 1'b0;

        edges = 0;
        while (!out_valid && edges < 40) begin
            // Noise on ignored inputs while the multiplier runs.
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            a         = W'($urandom);
            b         = W'($urandom);
            op        = 3'($urandom);
            tick();
            edges++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, ".latency"}, edges + 1, lat_exp);
        check({tag, ".result"}, int'(result), exp_res);
        check({tag, ".carry"}, int'(carry), exp_c);
        check({tag, ".zero"}, int'(zero), (exp_res == 0) ? 1 : 0);

        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a        = W'($urandom);
            b        = W'($urandom);
            op       = 3'($urandom);
            tick();
            check({tag, ".hold_valid"}, int'(out_valid), 1);
            check({tag, ".hold_result"}, int'(result), exp_res);
            check({tag, ".hold_carry"}, int'(carry), exp_c);
        end
        in_valid  = 1'b0;

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".post_valid"}, int'(out_valid), 0);
        check({tag, ".post_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        int o;
        int x;
        int y;

        // Power-on reset, released away from the clock edge.
        #2;
        check("por.in_ready", int'(in_ready), 1);
        check("por.out_valid", int'(out_valid), 0);
        tick();
        #1;
        rst = 1'b0;
        tick();

        // Leave an ADD result sitting in DONE, then reset mid-cycle.
        in_valid = 1'b1;
        op = 3'b000;
        a = 8'hF0;
        b = 8'h20;
        tick();
        in_valid = 1'b0;
        check("pre_rst.out_valid", int'(out_valid), 1);
        check("pre_rst.result", int'(result), 8'h10);
        #3;
        rst = 1'b1;
        #1;
        check("arst.in_ready", int'(in_ready), 1);
        check("arst.out_valid", int'(out_valid), 0);
        check("arst.result", int'(result), 0);
        check("arst.carry", int'(carry), 0);
        check("arst.zero", int'(zero), 0);
        tick();
        #1;
        rst = 1'b0;
        tick();

        // Directed cases.
        run_op(0, 8'hF0, 8'h20, 0, "add_ovf");
        run_op(1, 8'h05, 8'h07, 0, "sub_borrow");
        run_op(1, 8'h33, 8'h33, 0, "sub_zero");
        run_op(6, 8'h0C, 8'h0B, 0, "mul");
        run_op(6, 8'h10, 8'h20, 0, "mul_ovf");
        run_op(6, 8'h5A, 8'h00, 0, "mul_by0");
        run_op(6, 8'hFF, 8'hFF, 0, "mul_max");
        run_op(4, 8'hAA, 8'hFF, 5, "xor_bp");
        run_op(5, 8'h12, 8'h34, 0, "pass_b");
        run_op(7, 8'h12, 8'h34, 0, "pass_a");

        // Abort a multiply four cycles into BUSY.
        in_valid = 1'b1;
        op = 3'b110;
        a = 8'h0C;
        b = 8'h0B;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("abort.busy", int'(in_ready), 0);
        #2;
        rst = 1'b1;
        #1;
        check("abort.out_valid", int'(out_valid), 0);
        check("abort.in_ready", int'(in_ready), 1);
        tick();
        #1;
        rst = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            check("abort.no_valid", int'(out_valid), 0);
        end
        run_op(0, 8'h01, 8'h01, 0, "post_abort_add");

        // Randomized operations.
        for (int n = 0; n < 60; n++) begin
            o = int'($urandom_range(0, 7));
            x = int'($urandom_range(0, 255));
            y = int'($urandom_range(0, 255));
            run_op(o, x, y, int'($urandom_range(0, 3)), $sformatf("rnd%0d_op%0d", n, o));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
